stopwatch_ctrl: RTL and testbench

Push-button front end for the 6-digit BCD counter/display chain. It debounces two raw board buttons and runs a start/stop/lap/clear state machine. It drives the counters' `enable`, a one-cycle `clr` pulse for the counters' clear input, and a `hold` level that freezes the multiplexed display during a lap. It sits directly upstream of the counter bank and replaces the raw enable switch.

---
 rtl/stopwatch_ctrl_pkg.sv | 34 +++
 rtl/stopwatch_ctrl_key_debounce.sv | 78 +++++++
 rtl/stopwatch_ctrl.sv | 125 ++++++++++++
 tb/tb_stopwatch_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/stopwatch_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// stopwatch_ctrl_pkg
// Common definitions for the stopwatch front end: FSM state encodings (also
// shown on the debug LEDs), the default debounce length, and small helpers
// that map a state to its enable/hold output levels.
// ----------------------------------------------------------------------------
package stopwatch_ctrl_pkg;

   // 20 ms at a 50 MHz system clock
   localparam int DEB_CYCLES_DEFAULT = 1000000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_LAP   = 2'b10,
      ST_PAUSE = 2'b11
   } sw_state_e;

   // Counter bank runs in RUN and LAP; LAP only freezes the display.
   function automatic logic st_enable(input sw_state_e st);
      case (st)
         ST_RUN, ST_LAP: return 1'b1;
         default:        return 1'b0;
      endcase
   endfunction

   function automatic logic st_hold(input sw_state_e st);
      case (st)
         ST_LAP:  return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_key_debounce.sv
// ----------------------------------------------------------------------------
// key_debounce
// Synchronizes one raw push button, debounces it and emits a single-cycle
// press event for each accepted rising edge. Releases are debounced but give
// no event.
// Ports:
//   clk    - system clock
//   reset  - synchronous, active-high
//   btn_in - raw button, active-high, asynchronous to clk
//   press  - one-cycle pulse per accepted press (combinational from regs)
// ----------------------------------------------------------------------------
module key_debounce
   import stopwatch_ctrl_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_in,
   output logic press
);

   localparam int             CW        = $clog2(DEB_CYCLES);
   localparam logic [CW-1:0]  CNT_LAST  = CW'(DEB_CYCLES - 1);
   localparam logic [CW-1:0]  CNT_ZERO  = CW'(0);
   localparam logic [CW-1:0]  CNT_ONE   = CW'(1);

   logic          sync1_r;
   logic          sync_r;
   logic          stable_r;
   logic          stable_d_r;
   logic [CW-1:0] cnt_r;
   // Counts the cycles after reset until sync_r holds a real button sample;
   // at that point stable/stable_d are loaded directly so that a button held
   // through reset is treated as already pressed and produces no event.
   logic [1:0]    prime_r;

   // Synchronizer, debounce counter and stable/stable_d history.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_r    <= 1'b0;
         sync_r     <= 1'b0;
         stable_r   <= 1'b0;
         stable_d_r <= 1'b0;
         cnt_r      <= CNT_ZERO;
         prime_r    <= 2'd0;
      end else begin
         sync1_r <= btn_in;
         sync_r  <= sync1_r;
         if (prime_r != 2'd3) begin
            prime_r <= prime_r + 2'd1;
            cnt_r   <= CNT_ZERO;
            if (prime_r == 2'd2) begin
               stable_r   <= sync_r;
               stable_d_r <= sync_r;
            end else begin
               stable_r   <= 1'b0;
               stable_d_r <= 1'b0;
            end
         end else begin
            stable_d_r <= stable_r;
            if (sync_r != stable_r) begin
               if (cnt_r == CNT_LAST) begin
                  stable_r <= sync_r;
                  cnt_r    <= CNT_ZERO;
               end else begin
                  cnt_r    <= cnt_r + CNT_ONE;
               end
            end else begin
               cnt_r <= CNT_ZERO;
            end
         end
      end
   end

   assign press = stable_r & ~stable_d_r;

endmodule

// File: rtl/stopwatch_ctrl.sv
// ----------------------------------------------------------------------------
// stopwatch_ctrl
// Push-button front end for the BCD counter/display chain. Debounces the
// start/stop and lap/clear buttons and runs the IDLE/RUN/LAP/PAUSE machine.
// Ports:
//   clk       - system clock
//   reset     - synchronous, active-high
//   btn_start - raw start/stop button
//   btn_lap   - raw lap/clear button
//   enable    - counter bank count enable (registered)
//   clr       - one-cycle counter clear pulse (registered)
//   hold      - display freeze level for lap view (registered)
//   state     - current FSM state for LEDs/debug
// ----------------------------------------------------------------------------
module stopwatch_ctrl
   import stopwatch_ctrl_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_start,
   input  logic       btn_lap,
   output logic       enable,
   output logic       clr,
   output logic       hold,
   output logic [1:0] state
);

   logic      start_press_s;
   logic      lap_press_s;
   sw_state_e state_r;
   sw_state_e next_state_s;
   logic      next_clr_s;
   logic      enable_r;
   logic      hold_r;
   logic      clr_r;

   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
      .clk    (clk),
      .reset  (reset),
      .btn_in (btn_start),
      .press  (start_press_s)
   );

   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lap (
      .clk    (clk),
      .reset  (reset),
      .btn_in (btn_lap),
      .press  (lap_press_s)
   );

   // Next-state and clear decode; start is tested first so it wins a tie
   // and the simultaneous lap press is simply dropped.
   always_comb begin
      next_state_s = state_r;
      next_clr_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start_press_s) begin
               next_state_s = ST_RUN;
            end else if (lap_press_s) begin
               next_state_s = ST_IDLE;
               next_clr_s   = 1'b1;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (start_press_s) begin
               next_state_s = ST_PAUSE;
            end else if (lap_press_s) begin
               next_state_s = ST_LAP;
            end else begin
               next_state_s = ST_RUN;
            end
         end
         ST_LAP: begin
            if (start_press_s) begin
               next_state_s = ST_PAUSE;
            end else if (lap_press_s) begin
               next_state_s = ST_RUN;
            end else begin
               next_state_s = ST_LAP;
            end
         end
         ST_PAUSE: begin
            if (start_press_s) begin
               next_state_s = ST_RUN;
            end else if (lap_press_s) begin
               next_state_s = ST_IDLE;
               next_clr_s   = 1'b1;
            end else begin
               next_state_s = ST_PAUSE;
            end
         end
         default: begin
            next_state_s = ST_IDLE;
            next_clr_s   = 1'b0;
         end
      endcase
   end

   // State and output registers; outputs are decoded from the next state so
   // they change on the same edge as the state itself.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= ST_IDLE;
         enable_r <= 1'b0;
         hold_r   <= 1'b0;
         clr_r    <= 1'b0;
      end else begin
         state_r  <= next_state_s;
         enable_r <= st_enable(next_state_s);
         hold_r   <= st_hold(next_state_s);
         clr_r    <= next_clr_s;
      end
   end

   assign state  = state_r;
   assign enable = enable_r;
   assign hold   = hold_r;
   assign clr    = clr_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_stopwatch_ctrl
// Directed, table-driven bench for stopwatch_ctrl with DEB_CYCLES = 4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

   localparam int DEB = 4;

   // {state[1:0], enable, hold, clr}
   localparam logic [4:0] O_IDLE   = 5'b00_0_0_0;
   localparam logic [4:0] O_CLR    = 5'b00_0_0_1;
   localparam logic [4:0] O_RUN    = 5'b01_1_0_0;
   localparam logic [4:0] O_LAP    = 5'b10_1_1_0;
   localparam logic [4:0] O_PAUSE  = 5'b11_0_0_0;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn_start;
   logic       btn_lap;
   logic       enable;
   logic       clr;
   logic       hold;
   logic [1:0] state;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       start;
      logic       lap;
      int         cycles;
      logic       chk_all;
      logic [4:0] exp;
      string      name;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   stopwatch_ctrl #(.DEB_CYCLES(DEB)) dut (
      .clk       (clk),
      .reset     (reset),
      .btn_start (btn_start),
      .btn_lap   (btn_lap),
      .enable    (enable),
      .clr       (clr),
      .hold      (hold),
      .state     (state)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [4:0] exp);
      logic [4:0] act;
      act = {state, enable, hold, clr};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got state=%b en=%b hold=%b clr=%b, want state=%b en=%b hold=%b clr=%b",
                  name, $time, act[4:3], act[2], act[1], act[0],
                  exp[4:3], exp[2], exp[1], exp[0]);
      end
   endtask

   task automatic add(input logic s, input logic l, input int n,
                      input logic all, input logic [4:0] e, input string nm);
      vec_t v;
      v.start = s; v.lap = l; v.cycles = n; v.chk_all = all; v.exp = e; v.name = nm;
      vecs.push_back(v);
   endtask

   initial begin
      // Raw edge set after edge k is seen by the outputs at edge k+7.
      add(1'b1, 1'b0, 6,  1'b1, O_IDLE,  "start_wait");
      add(1'b1, 1'b0, 1,  1'b0, O_RUN,   "start_latency");
      add(1'b1, 1'b0, 3,  1'b1, O_RUN,   "start_hold");
      add(1'b0, 1'b0, 10, 1'b1, O_RUN,   "start_release");
      add(1'b1, 1'b0, 6,  1'b1, O_RUN,   "stop_wait");
      add(1'b1, 1'b0, 1,  1'b0, O_PAUSE, "stop_pause");
      add(1'b0, 1'b0, 10, 1'b1, O_PAUSE, "pause_steady");
      add(1'b1, 1'b0, 7,  1'b0, O_RUN,   "resume_run");
      add(1'b0, 1'b0, 10, 1'b1, O_RUN,   "run_steady");
      // bounce rejection
      add(1'b0, 1'b1, 1,  1'b1, O_RUN,   "bounce_1a");
      add(1'b0, 1'b0, 1,  1'b1, O_RUN,   "bounce_0a");
      add(1'b0, 1'b1, 1,  1'b1, O_RUN,   "bounce_1b");
      add(1'b0, 1'b0, 1,  1'b1, O_RUN,   "bounce_0b");
      add(1'b0, 1'b1, 3,  1'b1, O_RUN,   "bounce_3a");
      add(1'b0, 1'b0, 3,  1'b1, O_RUN,   "bounce_gap");
      add(1'b0, 1'b1, 3,  1'b1, O_RUN,   "bounce_3b");
      add(1'b0, 1'b0, 10, 1'b1, O_RUN,   "bounce_quiet");
      add(1'b0, 1'b1, 6,  1'b1, O_RUN,   "lap_wait");
      add(1'b0, 1'b0, 1,  1'b0, O_LAP,   "lap_enter");
      add(1'b0, 1'b0, 10, 1'b1, O_LAP,   "lap_steady");
      // lap -> pause -> clear
      add(1'b1, 1'b0, 6,  1'b1, O_LAP,   "lap_start_wait");
      add(1'b1, 1'b0, 1,  1'b0, O_PAUSE, "lap_to_pause");
      add(1'b0, 1'b0, 10, 1'b1, O_PAUSE, "pause_steady2");
      add(1'b0, 1'b1, 6,  1'b1, O_PAUSE, "clear_wait");
      add(1'b0, 1'b1, 1,  1'b0, O_CLR,   "clear_pulse");
      add(1'b0, 1'b1, 1,  1'b0, O_IDLE,  "clear_one_cycle");
      add(1'b0, 1'b0, 10, 1'b1, O_IDLE,  "idle_steady");
      // simultaneous presses in RUN
      add(1'b1, 1'b0, 7,  1'b0, O_RUN,   "run_again");
      add(1'b0, 1'b0, 10, 1'b1, O_RUN,   "run_steady2");
      add(1'b1, 1'b1, 6,  1'b1, O_RUN,   "both_wait");
      add(1'b1, 1'b1, 1,  1'b0, O_PAUSE, "both_start_wins");
      add(1'b1, 1'b1, 5,  1'b1, O_PAUSE, "both_held");
      add(1'b0, 1'b0, 15, 1'b1, O_PAUSE, "no_late_lap");
      // walk to LAP for the reset-mid-operation case
      add(1'b1, 1'b0, 7,  1'b0, O_RUN,   "run_third");
      add(1'b0, 1'b0, 10, 1'b1, O_RUN,   "run_steady3");
      add(1'b0, 1'b1, 7,  1'b0, O_LAP,   "lap_again");
      add(1'b0, 1'b0, 10, 1'b1, O_LAP,   "lap_before_reset");

      // Reset held 3 cycles with start held
      reset = 1'b1; btn_start = 1'b1; btn_lap = 1'b0;
      repeat (3) begin
         tick();
         check("reset_state", O_IDLE);
      end
      reset = 1'b0;
      repeat (20) begin
         tick();
         check("held_after_reset", O_IDLE);
      end
      btn_start = 1'b0;
      repeat (10) begin
         tick();
         check("release_after_reset", O_IDLE);
      end

      foreach (vecs[i]) begin
         btn_start = vecs[i].start;
         btn_lap   = vecs[i].lap;
         for (int c = 0; c < vecs[i].cycles; c++) begin
            tick();
            if (vecs[i].chk_all || c == vecs[i].cycles - 1)
               check(vecs[i].name, vecs[i].exp);
         end
      end

      // Reset two cycles into a start debounce while in LAP
      btn_start = 1'b1;
      repeat (2) begin
         tick();
         check("pre_reset_lap", O_LAP);
      end
      reset = 1'b1;
      repeat (2) begin
         tick();
         check("reset_mid", O_IDLE);
      end
      reset = 1'b0;
      repeat (12) begin
         tick();
         check("no_event_after_reset", O_IDLE);
      end
      btn_start = 1'b0;
      repeat (10) begin
         tick();
         check("idle_after_reset", O_IDLE);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
